fifo1_rr_arbiter: RTL and testbench
===================================

Name: fifo1_rr_arbiter

Overview:
- Shares one single-entry WIDTH-bit holding buffer between NREQ requesters using round-robin arbitration.
- The buffer is the same element/full pair used by the one-element FIFO.
- Sits between several producers (e.g. per-lane precision units) and one consumer. Each transfer carries a source tag, so the consumer knows which requester produced the data.
- Uses the codebase method handshake: a __RDY is never a function of any __ENA.

Parameters:
- NREQ, default 4: number of requesters, 2..16.
- WIDTH, default 16: payload width in bits.
- TAGW, default $clog2(NREQ): tag width; minimum 1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- in$req  input  NREQ  level request per requester; must stay high until the enq is accepted.
- in$enq__ENA  input  NREQ  enq strobe per requester; legal only when the matching in$enq__RDY is high.
- in$enq$v  input  NREQ*WIDTH  payload per requester; slice i is bits [i*WIDTH +: WIDTH].
- in$enq__RDY  output  NREQ  one-hot grant, or all zero.
- out$deq__ENA  input  1  consumer dequeue strobe.
- out$deq__RDY  output  1  buffer holds data.
- out$first  output  WIDTH  buffered payload.
- out$first__RDY  output  1  equals out$deq__RDY.
- out$firstTag  output  TAGW  index of the requester that wrote the buffer.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high. Ports are CLK and RST.
- State registers:
  - element[WIDTH], full, tag[TAGW].
  - ptr[TAGW]: highest-priority index.
- Reset (RST high, asynchronous): element=0, full=0, tag=0, ptr=0.
  - Outputs while RST is high: in$enq__RDY=0, out$deq__RDY=0, out$first__RDY=0, out$first=0, out$firstTag=0.
- Grant, combinational:
  - Scan in$req starting at ptr, wrapping modulo NREQ.
  - The first set bit i gives grant=onehot(i); grant=0 if no request.
  - in$enq__RDY = grant when !full && !RST, else 0.
  - Depends only on in$req, ptr, full. Never on in$enq__ENA.
- Enqueue: if in$enq__ENA[i] && in$enq__RDY[i]:
  - element <= slice i, tag <= i, full <= 1.
  - ptr <= (i+1) mod NREQ. Wrap: i=NREQ-1 gives ptr=0.
- Illegal enq:
  - in$enq__ENA[j] with in$enq__RDY[j]=0 is ignored: no state change.
  - Multiple ENA bits are ignored except the granted one.
- Dequeue: if out$deq__ENA && full, then full <= 0. element and tag are held (not cleared).
  - out$deq__ENA with full=0 is ignored.
- No bypass, no simultaneous enq/deq:
  - enq requires full=0, deq requires full=1, so they are mutually exclusive per cycle.
  - Peak throughput is one transfer per 2 cycles.
  - Latency from accepted enq to out$first__RDY is 1 cycle.
- ptr changes only on an accepted enq. Idle cycles and deq leave it unchanged.
- Fairness: a requester holding in$req high is granted within NREQ accepted enqs.
- Dropping in$req while granted, before ENA: the grant moves combinationally the same cycle. No state change.
- Reset asserted mid-transfer: buffered data is discarded (full=0) and ptr returns to 0.
  - After RST deasserts, arbitration restarts at index 0.

Decomposition:
- Package fifo1_arb_pkg:
  - WIDTH_DEFAULT=16, NREQ_DEFAULT=4.
  - Function tagw(n) returning max(1,$clog2(n)).
  - typedef tag_t.
- Sub-module rr_pick (combinational): inputs req[NREQ] and ptr[TAGW]; outputs grant[NREQ] one-hot and idx[TAGW], plus valid.
  - Reusable by later schedulers.
- Storage and ptr live in the top module.

Test Plan (NREQ=4, WIDTH=16):
- Reset: RST pulsed mid-cycle with in$req=4'b1111 -> all RDY low at once, asynchronously. After release: in$enq__RDY=4'b0001, out$deq__RDY=0, out$first=0.
- Single requester: req=4'b0100, enq v=16'hBEEF -> next cycle out$first=16'hBEEF, out$firstTag=2, full=1, in$enq__RDY=0. Deq -> full=0, ptr=3, RDY=4'b0100.
- Round robin: req=4'b1111 held, consumer deqs every time the buffer is full -> grant order 0,1,2,3,0. Tags observed 0,1,2,3,0 with payloads 16'h0010,16'h0011,16'h0012,16'h0013,16'h0014.
- Wrap and skip: ptr=3, req=4'b0101 -> grant=4'b0001. After enq, ptr=1 and the next grant goes to 2.
- Illegal strobes: full=1 with in$enq__ENA=4'b1111, v=16'hDEAD -> out$first unchanged, tag unchanged. Also full=0 with out$deq__ENA=1 -> no change.
- RDY independence: toggle in$enq__ENA while RDY is sampled -> RDY is identical with ENA=0 and ENA=1 for every cycle (checked by assertion).

Source files
------------

// File: rtl/fifo1_arb_pkg.sv
// Shared constants, tag sizing helper and tag type for the round-robin
// single-entry buffer arbiter and later schedulers.
package fifo1_arb_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int NREQ_DEFAULT  = 4;

  function automatic int tagw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [tagw(NREQ_DEFAULT)-1:0] tag_t;

endpackage

// File: rtl/fifo1_rr_arbiter_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NREQ. Returns the one-hot grant, its index and a valid flag.
module rr_pick
  import fifo1_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int TAGW = tagw(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [TAGW-1:0] ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [TAGW-1:0] idx_o,
  output logic            valid_o
);

  always_comb begin
    int j;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (!valid_o && req_i[j]) begin
        grant_o[j] = 1'b1;
        idx_o      = TAGW'(j);
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo1_rr_arbiter.sv
// NREQ producers share one single-entry holding buffer; round-robin grant,
// source tag travels with the data. Enq RDY depends only on req, ptr and full.
module fifo1_rr_arbiter
  import fifo1_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int TAGW  = tagw(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       in_req,
  input  logic [NREQ-1:0]       in_enq__ENA,
  input  logic [NREQ*WIDTH-1:0] in_enq_v,
  output logic [NREQ-1:0]       in_enq__RDY,
  input  logic                  out_deq__ENA,
  output logic                  out_deq__RDY,
  output logic [WIDTH-1:0]      out_first,
  output logic                  out_first__RDY,
  output logic [TAGW-1:0]       out_firstTag
);

  logic [WIDTH-1:0] element_q, element_d;
  logic             full_q, full_d;
  logic [TAGW-1:0]  tag_q, tag_d;
  logic [TAGW-1:0]  ptr_q, ptr_d;

  logic [NREQ-1:0]  pick_grant;
  logic [TAGW-1:0]  pick_idx;
  logic             pick_valid;
  logic [WIDTH-1:0] enq_data;
  logic             enq_fire, deq_fire;

  rr_pick #(.NREQ(NREQ), .TAGW(TAGW)) u_pick (
    .req_i   (in_req),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // RST gating keeps RDY low for the whole reset window, not just after the edge.
  assign in_enq__RDY    = (!full_q && !RST && pick_valid) ? pick_grant : '0;
  assign out_deq__RDY   = full_q;
  assign out_first__RDY = full_q;
  assign out_first      = element_q;
  assign out_firstTag   = tag_q;

  // Only the granted strobe counts; stray ENA bits fall out of the AND.
  assign enq_fire = |(in_enq__ENA & in_enq__RDY);
  assign deq_fire = out_deq__ENA && full_q;

  always_comb begin
    enq_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick_grant[i]) enq_data = in_enq_v[i*WIDTH +: WIDTH];
  end

  always_comb begin
    element_d = element_q;
    full_d    = full_q;
    tag_d     = tag_q;
    ptr_d     = ptr_q;
    if (enq_fire) begin
      element_d = enq_data;
      tag_d     = pick_idx;
      full_d    = 1'b1;
      ptr_d     = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + TAGW'(1);
    end else if (deq_fire) begin
      full_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      element_q <= '0;
      full_q    <= 1'b0;
      tag_q     <= '0;
      ptr_q     <= '0;
    end else begin
      element_q <= element_d;
      full_q    <= full_d;
      tag_q     <= tag_d;
      ptr_q     <= ptr_d;
    end
  end

endmodule

// File: tb/tb_fifo1_rr_arbiter.sv
// Vector table plus scoreboard for the round-robin single-entry buffer arbiter.
module tb_fifo1_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;

  logic              clk, rst;
  logic [3:0]        req, ena, rdy;
  logic [63:0]       vbus;
  logic              deq_ena, deq_rdy, first_rdy;
  logic [15:0]       first;
  logic [1:0]        ftag;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]  tag;
    logic [15:0] data;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  ena;
    logic [15:0] v;
    logic        deq;
    logic [3:0]  erdy;
    logic        efull;
    logic        chk;
    logic [15:0] efirst;
    logic [1:0]  etag;
  } vec_t;
  vec_t vecs[$];

  fifo1_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .CLK            (clk),
    .RST            (rst),
    .in_req         (req),
    .in_enq__ENA    (ena),
    .in_enq_v       (vbus),
    .in_enq__RDY    (rdy),
    .out_deq__ENA   (deq_ena),
    .out_deq__RDY   (deq_rdy),
    .out_first      (first),
    .out_first__RDY (first_rdy),
    .out_firstTag   (ftag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Same payload on every slice so whichever slice is granted carries v.
  function automatic logic [63:0] rep(input logic [15:0] v);
    return {v, v, v, v};
  endfunction

  task automatic add(input logic [3:0] rq, input logic [3:0] en, input logic [15:0] v,
                     input logic dq, input logic [3:0] er, input logic ef,
                     input logic ck, input logic [15:0] efi, input logic [1:0] et);
    vec_t x;
    x.req = rq; x.ena = en; x.v = v; x.deq = dq; x.erdy = er; x.efull = ef;
    x.chk = ck; x.efirst = efi; x.etag = et;
    vecs.push_back(x);
  endtask

  initial begin
    sb_t  e;
    vec_t x;
    logic [3:0] r0;

    rst = 1'b1; req = 4'b1111; ena = '0; vbus = '0; deq_ena = 1'b0;

    // Round robin, consumer drains every full cycle; starts at ptr=0
    add(4'b1111, 4'b0001, 16'h0010, 0, 4'b0001, 0, 0, 0, 0);
    add(4'b1111, 4'b0000, 16'h0000, 1, 4'b0000, 1, 1, 16'h0010, 0);
    add(4'b1111, 4'b0010, 16'h0011, 0, 4'b0010, 0, 0, 0, 0);
    add(4'b1111, 4'b0000, 16'h0000, 1, 4'b0000, 1, 1, 16'h0011, 1);
    add(4'b1111, 4'b0100, 16'h0012, 0, 4'b0100, 0, 0, 0, 0);
    add(4'b1111, 4'b0000, 16'h0000, 1, 4'b0000, 1, 1, 16'h0012, 2);
    add(4'b1111, 4'b1000, 16'h0013, 0, 4'b1000, 0, 0, 0, 0);
    add(4'b1111, 4'b0000, 16'h0000, 1, 4'b0000, 1, 1, 16'h0013, 3);
    add(4'b1111, 4'b0001, 16'h0014, 0, 4'b0001, 0, 0, 0, 0);
    add(4'b1111, 4'b0000, 16'h0000, 1, 4'b0000, 1, 1, 16'h0014, 0);
    // Single requester 2 (ptr=1 here), then illegal strobes while full
    add(4'b0100, 4'b0100, 16'hBEEF, 0, 4'b0100, 0, 0, 0, 0);
    add(4'b0000, 4'b0000, 16'h0000, 0, 4'b0000, 1, 1, 16'hBEEF, 2);
    add(4'b1111, 4'b1111, 16'hDEAD, 0, 4'b0000, 1, 1, 16'hBEEF, 2);
    add(4'b0100, 4'b0000, 16'h0000, 1, 4'b0000, 1, 1, 16'hBEEF, 2);
    // Deq on empty ignored; ptr=3 so req 2 still granted; data held
    add(4'b0100, 4'b0000, 16'h0000, 1, 4'b0100, 0, 1, 16'hBEEF, 2);
    // Wrap and skip from ptr=3
    add(4'b0101, 4'b0001, 16'h1234, 0, 4'b0001, 0, 0, 0, 0);
    add(4'b0101, 4'b0000, 16'h0000, 1, 4'b0000, 1, 1, 16'h1234, 0);
    add(4'b0101, 4'b0100, 16'h5678, 0, 4'b0100, 0, 0, 0, 0);
    add(4'b0000, 4'b0000, 16'h0000, 1, 4'b0000, 1, 1, 16'h5678, 2);

    // Reset held: everything low
    #12;
    chk("rst_enq_rdy", rdy, 4'b0000);
    chk("rst_deq_rdy", deq_rdy, 0);
    chk("rst_first", first, 16'h0);
    chk("rst_tag", ftag, 0);
    #6 rst = 1'b0;
    #1;
    chk("post_rst_rdy", rdy, 4'b0001);
    chk("post_rst_deq_rdy", deq_rdy, 0);
    chk("post_rst_first", first, 16'h0);
    step();

    foreach (vecs[n]) begin
      x = vecs[n];
      req = x.req; ena = 4'b0000; vbus = rep(x.v); deq_ena = x.deq;
      #1;
      r0 = rdy;
      chk($sformatf("v%0d_rdy", n), rdy, x.erdy);
      chk($sformatf("v%0d_full", n), deq_rdy, x.efull);
      chk($sformatf("v%0d_first_rdy", n), first_rdy, deq_rdy);
      if (x.chk) begin
        chk($sformatf("v%0d_first", n), first, x.efirst);
        chk($sformatf("v%0d_tag", n), ftag, x.etag);
      end
      ena = 4'b1111;
      #1 chk($sformatf("v%0d_rdy_ena_hi", n), rdy, r0);
      ena = x.ena;
      #1 chk($sformatf("v%0d_rdy_ena_set", n), rdy, r0);
      if ((ena & rdy) != 0) begin
        e.data = x.v;
        for (int i = 0; i < 4; i++) if (rdy[i]) e.tag = 2'(i);
        sbq.push_back(e);
      end
      if (deq_ena && deq_rdy) begin
        if (sbq.size() == 0) chk($sformatf("v%0d_sb_underflow", n), 1, 0);
        else begin
          e = sbq.pop_front();
          chk($sformatf("v%0d_sb_data", n), first, e.data);
          chk($sformatf("v%0d_sb_tag", n), ftag, e.tag);
        end
      end
      step();
    end
    chk("sb_empty", sbq.size(), 0);

    // Drop request while granted: grant moves the same cycle, ptr stays 3
    req = 4'b1000; ena = '0; deq_ena = 1'b0;
    #1 chk("drop_rdy_a", rdy, 4'b1000);
    req = 4'b0001;
    #1 chk("drop_rdy_b", rdy, 4'b0001);
    req = 4'b0000;
    step();
    req = 4'b1111;
    #1 chk("drop_ptr_kept", rdy, 4'b1000);

    // Reset mid-transfer discards data and returns ptr to 0
    ena = 4'b1000; vbus = rep(16'hAAAA);
    step();
    ena = '0;
    chk("mid_full", deq_rdy, 1);
    chk("mid_first", first, 16'hAAAA);
    chk("mid_tag", ftag, 3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_deq_rdy", deq_rdy, 0);
    chk("mid_rst_first", first, 16'h0);
    chk("mid_rst_tag", ftag, 0);
    chk("mid_rst_rdy", rdy, 4'b0000);
    #2 rst = 1'b0;
    #1 chk("mid_rst_ptr0", rdy, 4'b0001);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
